// File: rtl/gat_bridge_pkg.sv
// Shared types and helpers for the multi-channel BRAM load bridge.
// Run-state encoding, beat packing geometry and status bit positions.
package gat_bridge_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_BUSY  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int ST_STATE_LSB = 0;
   localparam int ST_DONE_LSB  = 3;

   function automatic int beats_of(input int word_w, input int bus_w);
      return (word_w + bus_w - 1) / bus_w;
   endfunction

   function automatic int slot_bits(input int beats);
      return (beats > 1) ? $clog2(beats) : 0;
   endfunction

   function automatic int st_busy_bit(input int num_ch);
      return ST_DONE_LSB + num_ch;
   endfunction

   function automatic int st_ovr_lsb(input int num_ch);
      return ST_DONE_LSB + num_ch + 1;
   endfunction

endpackage

// File: rtl/gat_bram_load_bridge_if.sv
// PS-side write bus and accelerator-side BRAM write bus, all channels.
// master drives PS beats and observes BRAM writes; slave is the bridge.
interface gat_bram_load_bridge_if #(
   parameter int NUM_CH  = 4,
   parameter int BUS_W   = 32,
   parameter int WORD_W  = 64,
   parameter int ADDR_W  = 20,
   parameter int WADDR_W = 17
);
   logic [NUM_CH-1:0]         ps_ena;
   logic [NUM_CH-1:0]         ps_wea;
   logic [NUM_CH*ADDR_W-1:0]  ps_addr;
   logic [NUM_CH*BUS_W-1:0]   ps_din;
   logic [NUM_CH-1:0]         bram_we;
   logic [NUM_CH*WADDR_W-1:0] bram_addr;
   logic [NUM_CH*WORD_W-1:0]  bram_din;

   modport master (
      output ps_ena, ps_wea, ps_addr, ps_din,
      input  bram_we, bram_addr, bram_din
   );

   modport slave (
      input  ps_ena, ps_wea, ps_addr, ps_din,
      output bram_we, bram_addr, bram_din
   );
endinterface

// File: rtl/gat_beat_packer.sv
// One load channel: gathers bus beats into a word, emits it, counts words.
// Tracks per-channel completion and the sticky overrun flag.
module gat_beat_packer
   import gat_bridge_pkg::*;
#(
   parameter int BUS_W   = 32,
   parameter int WORD_W  = 64,
   parameter int ADDR_W  = 20,
   parameter int WADDR_W = 17,
   parameter int CNT_W   = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               beat,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [BUS_W-1:0]   din,
   input  logic [CNT_W-1:0]   depth,
   input  logic               ext_done,
   output logic               we,
   output logic [WADDR_W-1:0] waddr,
   output logic [WORD_W-1:0]  wdata,
   output logic               done,
   output logic               overrun
);
   localparam int BEATS  = beats_of(WORD_W, BUS_W);
   localparam int SW     = slot_bits(BEATS);
   localparam int SIW    = (SW == 0) ? 1 : SW;
   localparam int PACK_W = BEATS * BUS_W;

   logic [BUS_W-1:0]   beat_q [BEATS];
   logic [BEATS-1:0]   vld_q;
   logic [WADDR_W-1:0] held_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [SIW-1:0]     slot;
   logic [WADDR_W-1:0] beat_wa;
   logic               miss;
   logic               full;
   logic [BEATS-1:0]   vld_nxt;
   logic [PACK_W-1:0]  pack;
   logic [CNT_W-1:0]   cnt_nxt;

   always_comb begin
      slot    = (BEATS > 1) ? SIW'(addr >> 2) : '0;
      beat_wa = WADDR_W'(addr >> (2 + SW));
      miss    = (|vld_q) && (beat_wa != held_q);
      // a beat for another word abandons the partial word
      vld_nxt       = miss ? '0 : vld_q;
      vld_nxt[slot] = 1'b1;
      full          = beat && (&vld_nxt);
      pack = '0;
      for (int i = 0; i < BEATS; i++)
         pack[i*BUS_W +: BUS_W] = (SIW'(i) == slot) ? din : beat_q[i];
      cnt_nxt = cnt_q;
      if (full && (depth == '0 || cnt_q < depth))
         cnt_nxt = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < BEATS; i++)
            beat_q[i] <= '0;
         vld_q   <= '0;
         held_q  <= '0;
         cnt_q   <= '0;
         done    <= 1'b0;
         overrun <= 1'b0;
         we      <= 1'b0;
         waddr   <= '0;
         wdata   <= '0;
      end else begin
         we <= full;
         if (beat) begin
            beat_q[slot] <= din;
            held_q       <= beat_wa;
            vld_q        <= full ? '0 : vld_nxt;
            if (miss)
               overrun <= 1'b1;
         end
         if (full) begin
            waddr <= beat_wa;
            wdata <= pack[WORD_W-1:0];
         end
         cnt_q <= cnt_nxt;
         done  <= done | ext_done | (depth != '0 && cnt_nxt == depth);
      end
   end

endmodule

// File: rtl/gat_bram_load_bridge.sv
// PS-to-accelerator BRAM load bridge: per-channel packers, run sequencer,
// registered feature readback and status word.
module gat_bram_load_bridge
   import gat_bridge_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int BUS_W     = 32,
   parameter int WORD_W    = 64,
   parameter int ADDR_W    = 20,
   parameter int WADDR_W   = 17,
   parameter int CNT_W     = 20,
   parameter int RD_DATA_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   gat_bram_load_bridge_if.slave   bus,
   input  logic [NUM_CH*CNT_W-1:0] cfg_depth,
   input  logic [NUM_CH-1:0]       ext_done,
   input  logic                    soft_clr,
   input  logic                    core_done,
   output logic                    core_start,
   output logic                    gat_ready,
   input  logic [ADDR_W-1:0]       rd_byte_addr,
   output logic [WADDR_W-1:0]      core_rd_addr,
   input  logic [RD_DATA_W-1:0]    core_rd_data,
   output logic [RD_DATA_W-1:0]    rd_dout,
   output logic [31:0]             status
);
   localparam int BUSY_BIT = st_busy_bit(NUM_CH);
   localparam int OVR_LSB  = st_ovr_lsb(NUM_CH);

   state_t                    state_q;
   state_t                    state_nxt;
   logic                      clr;
   logic                      accept;
   logic                      busy_wr_q;
   logic [NUM_CH-1:0]         wr;
   logic [NUM_CH-1:0]         done;
   logic [NUM_CH-1:0]         ovr;
   logic [NUM_CH-1:0]         we;
   logic [NUM_CH*WADDR_W-1:0] waddr;
   logic [NUM_CH*WORD_W-1:0]  wdata;

   assign wr     = bus.ps_ena & bus.ps_wea;
   assign accept = (state_q == S_IDLE) || (state_q == S_LOAD);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      gat_beat_packer #(
         .BUS_W   (BUS_W),
         .WORD_W  (WORD_W),
         .ADDR_W  (ADDR_W),
         .WADDR_W (WADDR_W),
         .CNT_W   (CNT_W)
      ) u_pack (
         .clk      (clk),
         .rst      (rst),
         .clr      (clr),
         .beat     (wr[g] & accept),
         .addr     (bus.ps_addr[g*ADDR_W +: ADDR_W]),
         .din      (bus.ps_din[g*BUS_W +: BUS_W]),
         .depth    (cfg_depth[g*CNT_W +: CNT_W]),
         .ext_done (ext_done[g]),
         .we       (we[g]),
         .waddr    (waddr[g*WADDR_W +: WADDR_W]),
         .wdata    (wdata[g*WORD_W +: WORD_W]),
         .done     (done[g]),
         .overrun  (ovr[g])
      );
   end

   assign bus.bram_we   = we;
   assign bus.bram_addr = waddr;
   assign bus.bram_din  = wdata;

   always_comb begin
      state_nxt = state_q;
      clr       = 1'b0;
      unique case (state_q)
         S_IDLE, S_LOAD: begin
            if (soft_clr) begin
               clr       = 1'b1;
               state_nxt = S_IDLE;
            end else if (&done) begin
               state_nxt = S_START;
            end else if (|wr) begin
               state_nxt = S_LOAD;
            end
         end
         S_START: state_nxt = S_BUSY;
         S_BUSY:  if (core_done) state_nxt = S_DONE;
         S_DONE: begin
            if (soft_clr) begin
               clr       = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         busy_wr_q <= 1'b0;
         rd_dout   <= '0;
      end else begin
         state_q <= state_nxt;
         rd_dout <= core_rd_data;
         // writes while the core owns the BRAMs are dropped and flagged
         if (clr)
            busy_wr_q <= 1'b0;
         else if ((|wr) && !accept)
            busy_wr_q <= 1'b1;
      end
   end

   assign core_start   = (state_q == S_START);
   assign gat_ready    = (state_q == S_DONE);
   assign core_rd_addr = WADDR_W'(rd_byte_addr >> 2);

   always_comb begin
      status = '0;
      status[ST_STATE_LSB +: 3]     = state_q;
      status[ST_DONE_LSB +: NUM_CH] = done;
      status[BUSY_BIT]              = busy_wr_q;
      status[OVR_LSB +: NUM_CH]     = ovr;
   end

endmodule

// File: tb/tb_gat_bram_load_bridge.sv
// Bench for gat_bram_load_bridge: vector table, run sequences,
// randomized beats against a word-assembly reference model.
module tb_gat_bram_load_bridge;
   import gat_bridge_pkg::*;

   localparam int NUM_CH    = 4;
   localparam int BUS_W     = 32;
   localparam int WORD_W    = 64;
   localparam int ADDR_W    = 20;
   localparam int WADDR_W   = 17;
   localparam int CNT_W     = 20;
   localparam int RD_DATA_W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst;
   logic [NUM_CH*CNT_W-1:0] cfg_depth;
   logic [NUM_CH-1:0]       ext_done;
   logic                    soft_clr;
   logic                    core_done;
   logic                    core_start;
   logic                    gat_ready;
   logic [ADDR_W-1:0]       rd_byte_addr;
   logic [WADDR_W-1:0]      core_rd_addr;
   logic [RD_DATA_W-1:0]    core_rd_data;
   logic [RD_DATA_W-1:0]    rd_dout;
   logic [31:0]             status;

   gat_bram_load_bridge_if #(
      .NUM_CH(NUM_CH), .BUS_W(BUS_W), .WORD_W(WORD_W),
      .ADDR_W(ADDR_W), .WADDR_W(WADDR_W)
   ) bus ();

   gat_bram_load_bridge #(
      .NUM_CH(NUM_CH), .BUS_W(BUS_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W),
      .WADDR_W(WADDR_W), .CNT_W(CNT_W), .RD_DATA_W(RD_DATA_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .cfg_depth    (cfg_depth),
      .ext_done     (ext_done),
      .soft_clr     (soft_clr),
      .core_done    (core_done),
      .core_start   (core_start),
      .gat_ready    (gat_ready),
      .rd_byte_addr (rd_byte_addr),
      .core_rd_addr (core_rd_addr),
      .core_rd_data (core_rd_data),
      .rd_dout      (rd_dout),
      .status       (status)
   );

   // core feature BRAM stand-in with one cycle of read latency
   function automatic logic [31:0] rd_mem(input logic [WADDR_W-1:0] a);
      return (a == 17'h10) ? 32'hDEADBEEF : ({15'h0, a} ^ 32'h5A5A0000);
   endfunction
   always @(posedge clk) core_rd_data <= rd_mem(core_rd_addr);

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle_in();
      bus.ps_ena = '0;
      bus.ps_wea = '0;
      ext_done   = '0;
      soft_clr   = 1'b0;
      core_done  = 1'b0;
   endtask

   task automatic drive(input int ch, input logic en,
                        input logic [19:0] a, input logic [31:0] d);
      bus.ps_ena[ch] = en;
      bus.ps_wea[ch] = 1'b1;
      bus.ps_addr[ch*ADDR_W +: ADDR_W] = a;
      bus.ps_din[ch*BUS_W +: BUS_W]    = d;
   endtask

   task automatic word(input int ch, input int wa,
                       input logic [31:0] d0, input logic [31:0] d1);
      drive(ch, 1'b1, 20'(wa * 8), d0);
      tick();
      idle_in();
      drive(ch, 1'b1, 20'(wa * 8 + 4), d1);
      tick();
      idle_in();
   endtask

   typedef struct {
      int          ch;
      logic        en;
      logic [19:0] a;
      logic [31:0] d;
      logic        we;
      logic [16:0] wa;
      logic [63:0] wd;
      logic [3:0]  ovr;
   } vec_t;
   vec_t tbl [13];

   // reference model: per channel, which slots of the open word are held
   typedef struct {
      int          c;
      int          ch;
      logic [16:0] wa;
      logic [63:0] wd;
   } wr_t;
   wr_t         expq [$];
   logic [31:0] pd [NUM_CH][2];
   bit          ph [NUM_CH][2];
   int          pwa [NUM_CH];
   logic [3:0]  ovr_m;

   task automatic model_beat(input int ch, input int wa, input int sl,
                             input logic [31:0] d);
      wr_t w;
      if ((ph[ch][0] || ph[ch][1]) && wa != pwa[ch]) begin
         ovr_m[ch] = 1'b1;
         ph[ch][0] = 0;
         ph[ch][1] = 0;
      end
      pwa[ch]    = wa;
      pd[ch][sl] = d;
      ph[ch][sl] = 1;
      if (ph[ch][0] && ph[ch][1]) begin
         w.c  = cyc + 1;
         w.ch = ch;
         w.wa = 17'(wa);
         w.wd = {pd[ch][1], pd[ch][0]};
         expq.push_back(w);
         ph[ch][0] = 0;
         ph[ch][1] = 0;
      end
   endtask

   task automatic check_writes();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         logic e;
         e = (expq.size() > 0) && (expq[0].c == cyc) && (expq[0].ch == ch);
         chk($sformatf("rnd_we_c%0d_ch%0d", cyc, ch),
             64'(bus.bram_we[ch]), 64'(e));
         if (e) begin
            if (bus.bram_we[ch]) begin
               chk("rnd_addr", 64'(bus.bram_addr[ch*WADDR_W +: WADDR_W]),
                   64'(expq[0].wa));
               chk("rnd_din", bus.bram_din[ch*WORD_W +: WORD_W], expq[0].wd);
            end
            void'(expq.pop_front());
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{0, 1'b1, 20'h00000, 32'h11111111, 1'b0, 17'h0, 64'h0, 4'h0};
      tbl[1]  = '{0, 1'b1, 20'h00004, 32'h22222222, 1'b1, 17'h0,
                  64'h22222222_11111111, 4'h0};
      tbl[2]  = '{1, 1'b1, 20'h0000C, 32'h33333333, 1'b0, 17'h0, 64'h0, 4'h0};
      tbl[3]  = '{1, 1'b0, 20'h00008, 32'hDEADDEAD, 1'b0, 17'h0, 64'h0, 4'h0};
      tbl[4]  = '{1, 1'b1, 20'h00008, 32'h44444444, 1'b1, 17'h1,
                  64'h33333333_44444444, 4'h0};
      tbl[5]  = '{2, 1'b1, 20'h00010, 32'h55555555, 1'b0, 17'h0, 64'h0, 4'h0};
      tbl[6]  = '{2, 1'b1, 20'h00020, 32'h66666666, 1'b0, 17'h0, 64'h0, 4'h4};
      tbl[7]  = '{2, 1'b1, 20'h00024, 32'h77777777, 1'b1, 17'h4,
                  64'h77777777_66666666, 4'h4};
      tbl[8]  = '{3, 1'b1, 20'h00001, 32'hAAAAAAAA, 1'b0, 17'h0, 64'h0, 4'h4};
      tbl[9]  = '{3, 1'b1, 20'h00003, 32'hBBBBBBBB, 1'b0, 17'h0, 64'h0, 4'h4};
      tbl[10] = '{3, 1'b1, 20'h00006, 32'hCCCCCCCC, 1'b1, 17'h0,
                  64'hCCCCCCCC_BBBBBBBB, 4'h4};
      tbl[11] = '{0, 1'b1, 20'hFFFFC, 32'h01234567, 1'b0, 17'h0, 64'h0, 4'h4};
      tbl[12] = '{0, 1'b1, 20'hFFFF8, 32'h89ABCDEF, 1'b1, 17'h1FFFF,
                  64'h01234567_89ABCDEF, 4'h4};

      rst          = 1'b1;
      idle_in();
      bus.ps_addr  = '0;
      bus.ps_din   = '0;
      cfg_depth    = '0;
      rd_byte_addr = '0;
      repeat (3) tick();
      chk("rst_we", 64'(bus.bram_we), 64'h0);
      chk("rst_status", 64'(status), 64'h0);
      chk("rst_start", 64'(core_start), 64'h0);
      chk("rst_ready", 64'(gat_ready), 64'h0);
      chk("rst_rd_dout", 64'(rd_dout), 64'h0);
      chk("rst_rd_addr", 64'(core_rd_addr), 64'h0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].ch, tbl[i].en, tbl[i].a, tbl[i].d);
         tick();
         idle_in();
         chk($sformatf("v%0d_we", i), 64'(bus.bram_we),
             tbl[i].we ? 64'(1 << tbl[i].ch) : 64'h0);
         if (tbl[i].we) begin
            chk($sformatf("v%0d_addr", i),
                64'(bus.bram_addr[tbl[i].ch*WADDR_W +: WADDR_W]),
                64'(tbl[i].wa));
            chk($sformatf("v%0d_din", i),
                bus.bram_din[tbl[i].ch*WORD_W +: WORD_W], tbl[i].wd);
         end
         chk($sformatf("v%0d_ovr", i), 64'(status[11:8]), 64'(tbl[i].ovr));
      end
      chk("tbl_state_load", 64'(status[2:0]), 64'h1);
      chk("tbl_done_none", 64'(status[6:3]), 64'h0);

      soft_clr = 1'b1;
      tick();
      idle_in();
      chk("clr_status", 64'(status), 64'h0);

      ovr_m = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         ph[ch][0] = 0;
         ph[ch][1] = 0;
         pwa[ch]   = 0;
      end
      repeat (400) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if ($urandom_range(0, 1) == 1) begin
               int          wa;
               int          sl;
               int          lo;
               logic [31:0] d;
               wa = $urandom_range(0, 3);
               sl = $urandom_range(0, 1);
               lo = $urandom_range(0, 3);
               d  = $urandom;
               drive(ch, 1'b1, 20'(wa * 8 + sl * 4 + lo), d);
               model_beat(ch, wa, sl, d);
            end
         end
         tick();
         idle_in();
         check_writes();
      end
      repeat (2) begin
         tick();
         check_writes();
      end
      chk("rnd_leftover", 64'(expq.size()), 64'h0);
      chk("rnd_ovr", 64'(status[11:8]), 64'(ovr_m));
      chk("rnd_done", 64'(status[6:3]), 64'h0);

      soft_clr = 1'b1;
      tick();
      idle_in();
      cfg_depth = {20'd0, 20'd1, 20'd1, 20'd2};
      word(0, 5, 32'h0A0A0A0A, 32'h0B0B0B0B);
      chk("run_done_ch0_partial", 64'(status[6:3]), 64'h0);
      word(0, 6, 32'h0C0C0C0C, 32'h0D0D0D0D);
      chk("run_done_ch0", 64'(status[6:3]), 64'h1);
      word(0, 7, 32'h0E0E0E0E, 32'h0F0F0F0F);
      chk("run_reload_we", 64'(bus.bram_we), 64'h1);
      chk("run_reload_din", bus.bram_din[63:0], 64'h0F0F0F0F_0E0E0E0E);
      chk("run_reload_done", 64'(status[6:3]), 64'h1);
      word(1, 0, 32'h1, 32'h2);
      word(2, 0, 32'h3, 32'h4);
      chk("run_done_012", 64'(status[6:3]), 64'h7);
      chk("run_state_load", 64'(status[2:0]), 64'h1);
      ext_done = 4'b1000;
      tick();
      idle_in();
      chk("run_done_all", 64'(status[6:3]), 64'hF);
      chk("run_no_start_yet", 64'(core_start), 64'h0);
      tick();
      chk("run_start", 64'(core_start), 64'h1);
      chk("run_state_start", 64'(status[2:0]), 64'h2);
      tick();
      chk("run_start_one", 64'(core_start), 64'h0);
      chk("run_state_busy", 64'(status[2:0]), 64'h3);
      word(0, 9, 32'h99, 32'h98);
      chk("busy_wr_dropped", 64'(bus.bram_we), 64'h0);
      chk("busy_wr_flag", 64'(status[7]), 64'h1);
      chk("busy_state", 64'(status[2:0]), 64'h3);
      core_done = 1'b1;
      tick();
      idle_in();
      chk("done_ready", 64'(gat_ready), 64'h1);
      chk("done_state", 64'(status[2:0]), 64'h4);
      tick();
      chk("done_hold", 64'(gat_ready), 64'h1);
      soft_clr = 1'b1;
      tick();
      idle_in();
      chk("clr2_status", 64'(status), 64'h0);
      chk("clr2_ready", 64'(gat_ready), 64'h0);

      cfg_depth = {4{20'd1}};
      for (int ch = 0; ch < NUM_CH; ch++)
         drive(ch, 1'b1, 20'h0, 32'(ch + 16));
      tick();
      idle_in();
      for (int ch = 0; ch < NUM_CH; ch++)
         drive(ch, 1'b1, 20'h4, 32'(ch + 32));
      tick();
      idle_in();
      chk("sim_we", 64'(bus.bram_we), 64'hF);
      chk("sim_din3", bus.bram_din[3*64 +: 64], 64'h00000023_00000013);
      chk("sim_done", 64'(status[6:3]), 64'hF);
      chk("sim_state", 64'(status[2:0]), 64'h1);
      tick();
      chk("sim_start", 64'(core_start), 64'h1);
      tick();
      chk("sim_busy", 64'(status[2:0]), 64'h3);
      core_done = 1'b1;
      tick();
      idle_in();
      soft_clr = 1'b1;
      tick();
      idle_in();
      chk("sim_clr", 64'(status), 64'h0);

      drive(0, 1'b1, 20'h0, 32'h55AA55AA);
      tick();
      idle_in();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(0, 1'b1, 20'h4, 32'h12345678);
      tick();
      idle_in();
      chk("rstmid_no_we", 64'(bus.bram_we), 64'h0);
      chk("rstmid_done", 64'(status[6:3]), 64'h0);
      drive(0, 1'b1, 20'h0, 32'h9ABCDEF0);
      tick();
      idle_in();
      chk("rstmid_we", 64'(bus.bram_we), 64'h1);
      chk("rstmid_din", bus.bram_din[63:0], 64'h12345678_9ABCDEF0);
      chk("rstmid_cnt", 64'(status[6:3]), 64'h1);

      rd_byte_addr = 20'h40;
      #1;
      chk("rd_addr", 64'(core_rd_addr), 64'h10);
      tick();
      chk("rd_lat1", 64'(rd_dout), 64'(rd_mem(17'h0)));
      tick();
      chk("rd_lat2", 64'(rd_dout), 64'h0DEADBEEF);
      rd_byte_addr = 20'h107;
      #1;
      chk("rd_addr2", 64'(core_rd_addr), 64'h41);
      tick();
      tick();
      chk("rd_data2", 64'(rd_dout), 64'h5A5A0041);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
